// File: rtl/uart_send_if.sv
// Byte-queue write port and serial-side status of the UART transmitter.
interface uart_send_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          i_tx_dv;
    logic [7:0]    i_tx_byte;
    logic          o_tx_ready;
    logic          o_tx_serial;
    logic          o_tx_active;
    logic          o_tx_done;
    logic [CW-1:0] o_fifo_count;

    modport master (
        output i_tx_dv,
        output i_tx_byte,
        input  o_tx_ready,
        input  o_tx_serial,
        input  o_tx_active,
        input  o_tx_done,
        input  o_fifo_count
    );

    modport slave (
        input  i_tx_dv,
        input  i_tx_byte,
        output o_tx_ready,
        output o_tx_serial,
        output o_tx_active,
        output o_tx_done,
        output o_fifo_count
    );
endinterface

// File: rtl/uart_send.sv
// 8N1 UART transmitter, LSB first, fed from a small byte FIFO.
// Frames are sent back to back while the FIFO holds data.
module uart_send #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input logic       i_Clk,
    input logic       i_Reset,
    uart_send_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ready, empty, push, pop;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          serial_q, serial_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          baud_last;

    assign ready     = count_q < CW'(FIFO_DEPTH);
    assign empty     = count_q == '0;
    assign push      = bus.i_tx_dv && ready;
    assign baud_last = baud_q == BAUD_LAST;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.i_tx_byte;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state so they align with the state register.
    always_comb begin
        serial_d = 1'b1;
        unique case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[bit_idx_d];
            default: serial_d = 1'b1;
        endcase
        active_d = state_d != IDLE;
        done_d   = (state_d == STOP) && (baud_d == BAUD_LAST);
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign bus.o_tx_ready   = ready;
    assign bus.o_tx_serial  = serial_q;
    assign bus.o_tx_active  = active_q;
    assign bus.o_tx_done    = done_q;
    assign bus.o_fifo_count = count_q;
endmodule
